axi_mem_tester: RTL and testbench
=================================

# axi_mem_tester

AXI4 master traffic generator and checker that drives the 128-bit `axi128` port of the DDR3 memory controller. After calibration completes and `start` is pulsed, it writes a deterministic address-derived pattern over a configurable region in fixed-length INCR bursts. It then reads the region back, compares every beat, and reports pass/fail, an error count and the first failing address. It is the on-board DDR3 bring-up and soak-test engine, clocked in the controller's user clock domain.

## Interface

Parameters:
- `ADDR_W`, 30: AXI address width (byte address).
- `DATA_W`, 128: AXI data width; fixed at 128.
- `BURST_LEN`, 16: beats per burst (1..256); `awlen`/`arlen` = BURST_LEN-1.
- `NUM_BURSTS`, 1024: bursts per pass (>=1).
- `BASE_ADDR`, 0: region start; must be aligned to BURST_LEN*16 bytes.

Ports:
- `mig_clk`  in  1  controller user clock; all logic on rising edge.
- `aresetn`  in  1  reset, synchronous and active-low.
- `calib_done`  in  1  `init_calib_complete` from the controller.
- `start`  in  1  single-cycle start pulse.
- `seed`  in  32  pattern seed, sampled when `start` is accepted.
- `axi128`  AXI.M  —  AXI4 master. IDs are unused.
- `busy`  out  1  high from start acceptance until done.
- `done`  out  1  level; high after a pass completes, cleared by the next accepted start.
- `pass`  out  1  `done && err_count==0`.
- `err_count`  out  16  saturating error count.
- `first_err_addr`  out  ADDR_W  beat address of the first error.

## Operation

- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- Start acceptance:
  - `start` is accepted only in IDLE or DONE with `calib_done`=1; otherwise it is ignored.
  - On acceptance: burst counter=0, `err_count`=0, `first_err_addr`=0, `seed` latched, `done`=0. Next state is WR_ADDR.
- Burst address: burst n starts at `BASE_ADDR + n*BURST_LEN*16`. Beat b of a burst has address burst address + 16*b.
- Constant AXI fields:
  - size 3'b100, burst 2'b01 (INCR), lock 0, cache 4'b0011, prot 0, qos 0.
  - `wstrb` is all ones.
- Data pattern: for beat address A, 32-bit lane k (k=0..3, lane 0 in bits 31:0) = `(zero-extended A + k) ^ seed`, truncated to 32 bits.
- Write phase:
  - WR_ADDR: `awvalid`=1 until `awready`, then go to WR_DATA.
  - WR_DATA: `wvalid` high continuously; a beat advances on each `wready`. `wlast`=1 on beat BURST_LEN-1. After the last handshake, go to WR_RESP.
  - WR_RESP: `bready`=1. On `bvalid`, `bresp`!=OKAY counts one error at the burst address. Next state is WR_ADDR for the next burst, or RD_ADDR after burst NUM_BURSTS-1, with the burst counter reset to 0.
- Read phase:
  - RD_ADDR: `arvalid` until `arready`, then go to RD_DATA.
  - RD_DATA: `rready`=1. Each `rvalid` beat is compared against the expected pattern. A data mismatch, `rresp`!=OKAY, or `rlast` wrong for the beat index counts one error at the beat address (one per beat maximum).
  - On the beat with index BURST_LEN-1, go to RD_ADDR for the next burst or to DONE.
- Only one outstanding transaction at a time; AW and W never overlap.
- Error accounting:
  - `err_count` saturates at 16'hFFFF.
  - `first_err_addr` is written only on the error that takes `err_count` from 0 to 1.

## Timing

- Reset values, applied at the first edge with `aresetn`=0: state IDLE.
  - All valid/ready/last outputs = 0.
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0.
  - Address and data outputs = 0.
- Reset mid-burst aborts immediately; valids drop on that edge. This is the only permitted valid withdrawal.
- `awvalid` rises the cycle after `start` is accepted.
- `wvalid` rises the cycle after the AW handshake.
- With `wready` held high, one beat per cycle with no bubbles. Next-beat data is precomputed in registers.
- A valid stays asserted and its payload is stable until handshake; no combinational path from any ready to any valid.
- Read compare:
  - Expected data is registered and compared in the accepting cycle; `rready` stays high throughout RD_DATA.
  - `err_count` updates one cycle after the failing beat.
- `done` and `pass` rise the cycle after the final read beat. `busy` falls in the same cycle.
- Ideal slave (all readies high, zero latency): total cycles ≈ NUM_BURSTS*(2*BURST_LEN + 5).

## Test plan

- **Clean pass:** memory BFM, BURST_LEN=4, NUM_BURSTS=8, seed=0. Required:
  - AW addresses 0x000, 0x040, …, 0x1C0.
  - Beat 0 of burst 1 wdata = 0x00000043_00000042_00000041_00000040.
  - `done`=1, `pass`=1, `err_count`=0.
- **Injected error:** BFM corrupts bit 0 of the read beat at 0x050. Required: `err_count`=1, `first_err_addr`=0x050, `pass`=0.
- **Backpressure:** random `awready`/`wready`/`arready`, and `rvalid` gaps at 50%. Required: valids/payload stable until handshake, exactly BURST_LEN beats per burst, `wlast` only on beat 3, `pass`=1.
- **Gating:** `start` with `calib_done`=0 → no AXI activity, `busy`=0. `start` while `busy` → ignored; transaction count unchanged.
- **Response errors:** BFM returns SLVERR on write burst 2 and on one read beat. Required: `err_count`=2, `first_err_addr`=0x080.
- **Reset mid-WR_DATA:** `aresetn`=0 for 1 cycle after beat 1. Required: all outputs return to reset values next edge; a fresh `start` completes with `pass`=1.

Source files
------------

// File: rtl/axi_mem_tester.sv
// ---------------------------------------------------------------------------
// axi_mem_tester
//
// AXI4 master traffic generator and checker for DDR3 bring-up / soak tests.
// After calibration and a start pulse it writes an address-derived pattern
// over a region in fixed-length INCR bursts. It then reads the region back,
// compares every beat and reports pass/fail, a saturating error count and the
// first failing address. Only one AXI transaction is outstanding at a time.
//
// Ports
//   mig_clk_i          controller user clock, all logic on the rising edge
//   aresetn_i          synchronous active-low reset
//   calib_done_i       controller calibration complete
//   start_i            single-cycle start pulse
//   seed_i             pattern seed, latched when start is accepted
//   axi128_aw*/w*/b*   AXI4 write channels (master side, IDs unused)
//   axi128_ar*/r*      AXI4 read channels (master side, IDs unused)
//   busy_o             high from start acceptance until the pass finishes
//   done_o             high after a pass completes, cleared by the next start
//   pass_o             done_o with a zero error count
//   err_count_o        saturating error count
//   first_err_addr_o   beat address of the first error
// ---------------------------------------------------------------------------
module axi_mem_tester #(
    parameter int              ADDR_W     = 30,
    parameter int              DATA_W     = 128,
    parameter int              BURST_LEN  = 16,
    parameter int              NUM_BURSTS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                mig_clk_i,
    input  logic                aresetn_i,
    input  logic                calib_done_i,
    input  logic                start_i,
    input  logic [31:0]         seed_i,
    // write address channel
    output logic [ADDR_W-1:0]   axi128_awaddr_o,
    output logic [7:0]          axi128_awlen_o,
    output logic [2:0]          axi128_awsize_o,
    output logic [1:0]          axi128_awburst_o,
    output logic                axi128_awlock_o,
    output logic [3:0]          axi128_awcache_o,
    output logic [2:0]          axi128_awprot_o,
    output logic [3:0]          axi128_awqos_o,
    output logic                axi128_awvalid_o,
    input  logic                axi128_awready_i,
    // write data channel
    output logic [DATA_W-1:0]   axi128_wdata_o,
    output logic [DATA_W/8-1:0] axi128_wstrb_o,
    output logic                axi128_wlast_o,
    output logic                axi128_wvalid_o,
    input  logic                axi128_wready_i,
    // write response channel
    input  logic [1:0]          axi128_bresp_i,
    input  logic                axi128_bvalid_i,
    output logic                axi128_bready_o,
    // read address channel
    output logic [ADDR_W-1:0]   axi128_araddr_o,
    output logic [7:0]          axi128_arlen_o,
    output logic [2:0]          axi128_arsize_o,
    output logic [1:0]          axi128_arburst_o,
    output logic                axi128_arlock_o,
    output logic [3:0]          axi128_arcache_o,
    output logic [2:0]          axi128_arprot_o,
    output logic [3:0]          axi128_arqos_o,
    output logic                axi128_arvalid_o,
    input  logic                axi128_arready_i,
    // read data channel
    input  logic [DATA_W-1:0]   axi128_rdata_i,
    input  logic [1:0]          axi128_rresp_i,
    input  logic                axi128_rlast_i,
    input  logic                axi128_rvalid_i,
    output logic                axi128_rready_o,
    // status
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [15:0]         err_count_o,
    output logic [ADDR_W-1:0]   first_err_addr_o
);

    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_W   = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int NUM_LANES = DATA_W / 32;

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0]  BEAT_BYTES = ADDR_W'(16);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [31:0]        seed_q;
    logic [ADDR_W-1:0]  burst_addr_q;   // address of the current burst
    logic [ADDR_W-1:0]  beat_addr_q;    // address of the current beat
    logic [DATA_W-1:0]  data_q;         // pattern for beat_addr_q (wdata / expected rdata)
    logic [BEAT_W-1:0]  beat_cnt_q;
    logic [BURST_W-1:0] burst_cnt_q;
    logic [15:0]        err_count_q;
    logic [ADDR_W-1:0]  first_err_q;

    logic start_acc;
    logic last_beat;
    logic last_burst;
    logic w_hs;
    logic r_hs;
    logic b_hs;
    logic rd_bad;
    logic err_hit;
    logic [ADDR_W-1:0] err_addr;

    // Pattern loader: whenever the beat pointer moves, the pattern for the new
    // address is computed here and registered together with the address, so
    // the next beat's data is ready without a bubble.
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_addr32;
    logic [31:0]       seed_sel;
    logic [DATA_W-1:0] pat_load;

    assign start_acc  = start_i && calib_done_i &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_beat  = (beat_cnt_q == LAST_BEAT);
    assign last_burst = (burst_cnt_q == LAST_BURST);
    assign w_hs       = (state_q == ST_WR_DATA) && axi128_wready_i;
    assign r_hs       = (state_q == ST_RD_DATA) && axi128_rvalid_i;
    assign b_hs       = (state_q == ST_WR_RESP) && axi128_bvalid_i;

    // A read beat is bad on data mismatch, non-OKAY response or an rlast
    // that disagrees with the beat index; it still counts only once.
    assign rd_bad  = (axi128_rdata_i != data_q) ||
                     (axi128_rresp_i != 2'b00) ||
                     (axi128_rlast_i != last_beat);
    assign err_hit = (b_hs && (axi128_bresp_i != 2'b00)) || (r_hs && rd_bad);
    assign err_addr = (state_q == ST_WR_RESP) ? burst_addr_q : beat_addr_q;

    always_comb begin
        load_en   = 1'b0;
        load_addr = beat_addr_q;
        seed_sel  = seed_q;
        if (start_acc) begin
            load_en   = 1'b1;
            load_addr = BASE_ADDR;
            seed_sel  = seed_i;
        end else begin
            case (state_q)
                ST_WR_DATA: begin
                    if (w_hs) begin
                        load_en   = 1'b1;
                        load_addr = beat_addr_q + BEAT_BYTES;
                    end
                end
                ST_WR_RESP: begin
                    // After the last write burst rewind to the region start
                    // for the read-back pass.
                    if (b_hs && last_burst) begin
                        load_en   = 1'b1;
                        load_addr = BASE_ADDR;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        load_en   = 1'b1;
                        load_addr = beat_addr_q + BEAT_BYTES;
                    end
                end
                default: ;
            endcase
        end
    end

    assign load_addr32 = 32'(load_addr);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign pat_load[gi*32 +: 32] = (load_addr32 + 32'(gi)) ^ seed_sel;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge mig_clk_i) begin
        if (!aresetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) state_d = ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                if (axi128_awready_i) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (w_hs && last_beat) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (b_hs) state_d = last_burst ? ST_RD_ADDR : ST_WR_ADDR;
            end
            ST_RD_ADDR: begin
                if (axi128_arready_i) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (r_hs && last_beat) state_d = last_burst ? ST_DONE : ST_RD_ADDR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only, so no ready
    // ever reaches a valid combinationally)
    // ------------------------------------------------------------------
    always_comb begin
        axi128_awvalid_o = 1'b0;
        axi128_wvalid_o  = 1'b0;
        axi128_wlast_o   = 1'b0;
        axi128_bready_o  = 1'b0;
        axi128_arvalid_o = 1'b0;
        axi128_rready_o  = 1'b0;
        busy_o           = 1'b1;
        done_o           = 1'b0;
        case (state_q)
            ST_IDLE:    busy_o = 1'b0;
            ST_WR_ADDR: axi128_awvalid_o = 1'b1;
            ST_WR_DATA: begin
                axi128_wvalid_o = 1'b1;
                axi128_wlast_o  = last_beat;
            end
            ST_WR_RESP: axi128_bready_o  = 1'b1;
            ST_RD_ADDR: axi128_arvalid_o = 1'b1;
            ST_RD_DATA: axi128_rready_o  = 1'b1;
            ST_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
            end
            default:    busy_o = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address/beat/burst pointers, pattern and error tracking
    // ------------------------------------------------------------------
    always_ff @(posedge mig_clk_i) begin
        if (!aresetn_i) begin
            seed_q       <= '0;
            burst_addr_q <= '0;
            beat_addr_q  <= '0;
            data_q       <= '0;
            beat_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            err_count_q  <= '0;
            first_err_q  <= '0;
        end else begin
            if (load_en) begin
                beat_addr_q <= load_addr;
                data_q      <= pat_load;
            end
            if (start_acc) begin
                seed_q       <= seed_i;
                burst_addr_q <= BASE_ADDR;
                beat_cnt_q   <= '0;
                burst_cnt_q  <= '0;
                err_count_q  <= '0;
                first_err_q  <= '0;
            end else begin
                case (state_q)
                    ST_WR_DATA: begin
                        if (w_hs) beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
                    end
                    ST_WR_RESP: begin
                        if (b_hs) begin
                            // beat_addr_q already points one past the burst,
                            // i.e. at the next burst's start address.
                            burst_cnt_q  <= last_burst ? '0 : burst_cnt_q + 1'b1;
                            burst_addr_q <= last_burst ? BASE_ADDR : beat_addr_q;
                        end
                    end
                    ST_RD_DATA: begin
                        if (r_hs) begin
                            beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
                            if (last_beat) begin
                                burst_cnt_q  <= burst_cnt_q + 1'b1;
                                burst_addr_q <= beat_addr_q + BEAT_BYTES;
                            end
                        end
                    end
                    default: ;
                endcase

                if (err_hit) begin
                    if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
                    if (err_count_q == 16'd0)    first_err_q <= err_addr;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign axi128_awaddr_o  = burst_addr_q;
    assign axi128_awlen_o   = 8'(BURST_LEN - 1);
    assign axi128_awsize_o  = 3'b100;
    assign axi128_awburst_o = 2'b01;
    assign axi128_awlock_o  = 1'b0;
    assign axi128_awcache_o = 4'b0011;
    assign axi128_awprot_o  = 3'b000;
    assign axi128_awqos_o   = 4'b0000;

    assign axi128_wdata_o   = data_q;
    assign axi128_wstrb_o   = '1;

    assign axi128_araddr_o  = burst_addr_q;
    assign axi128_arlen_o   = 8'(BURST_LEN - 1);
    assign axi128_arsize_o  = 3'b100;
    assign axi128_arburst_o = 2'b01;
    assign axi128_arlock_o  = 1'b0;
    assign axi128_arcache_o = 4'b0011;
    assign axi128_arprot_o  = 3'b000;
    assign axi128_arqos_o   = 4'b0000;

    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_q;
    assign pass_o           = done_o && (err_count_q == 16'd0);

endmodule

// File: tb/tb_axi_mem_tester.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_tester
//
// Directed bench for axi_mem_tester with BURST_LEN=4, NUM_BURSTS=8. A small
// AXI slave model stores written beats and returns them on reads, with
// optional backpressure, read gaps, data corruption and error responses.
// ---------------------------------------------------------------------------
module tb_axi_mem_tester;

    localparam int ADDR_W = 30;
    localparam int BL     = 4;
    localparam int NB     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              aresetn = 1'b0;
    logic              calib_done = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       seed = '0;

    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic              awvalid;
    logic              awready = 1'b0;
    logic [127:0]      wdata;
    logic [15:0]       wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready = 1'b0;
    logic [1:0]        bresp = 2'b00;
    logic              bvalid = 1'b0;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [127:0]      rdata = '0;
    logic [1:0]        rresp = 2'b00;
    logic              rlast = 1'b0;
    logic              rvalid = 1'b0;
    logic              rready;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;

    axi_mem_tester #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (128),
        .BURST_LEN  (BL),
        .NUM_BURSTS (NB),
        .BASE_ADDR  ('0)
    ) dut (
        .mig_clk_i        (clk),
        .aresetn_i        (aresetn),
        .calib_done_i     (calib_done),
        .start_i          (start),
        .seed_i           (seed),
        .axi128_awaddr_o  (awaddr),
        .axi128_awlen_o   (awlen),
        .axi128_awsize_o  (awsize),
        .axi128_awburst_o (awburst),
        .axi128_awlock_o  (awlock),
        .axi128_awcache_o (awcache),
        .axi128_awprot_o  (awprot),
        .axi128_awqos_o   (awqos),
        .axi128_awvalid_o (awvalid),
        .axi128_awready_i (awready),
        .axi128_wdata_o   (wdata),
        .axi128_wstrb_o   (wstrb),
        .axi128_wlast_o   (wlast),
        .axi128_wvalid_o  (wvalid),
        .axi128_wready_i  (wready),
        .axi128_bresp_i   (bresp),
        .axi128_bvalid_i  (bvalid),
        .axi128_bready_o  (bready),
        .axi128_araddr_o  (araddr),
        .axi128_arlen_o   (arlen),
        .axi128_arsize_o  (arsize),
        .axi128_arburst_o (arburst),
        .axi128_arlock_o  (arlock),
        .axi128_arcache_o (arcache),
        .axi128_arprot_o  (arprot),
        .axi128_arqos_o   (arqos),
        .axi128_arvalid_o (arvalid),
        .axi128_arready_i (arready),
        .axi128_rdata_i   (rdata),
        .axi128_rresp_i   (rresp),
        .axi128_rlast_i   (rlast),
        .axi128_rvalid_i  (rvalid),
        .axi128_rready_o  (rready),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_count_o      (err_count),
        .first_err_addr_o (first_err_addr)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave model controls and statistics
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] none_addr = '1;
    bit                bp_mode = 1'b0;
    bit                rgap_mode = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '1;
    logic [ADDR_W-1:0] rerr_addr = '1;
    int                slverr_burst = -1;

    int                aw_count = 0;
    int                ar_count = 0;
    int                w_total = 0;
    int                r_total = 0;
    int                wlast_viol = 0;
    int                stab_viol = 0;
    logic [127:0]      cap_b1 = '0;
    logic [ADDR_W-1:0] aw_log [0:15];

    logic [127:0]      mem [0:63];

    // slave state
    logic [ADDR_W-1:0] cur_aw = '0;
    int                w_beat = 0;
    bit                b_pend = 1'b0;
    bit                r_active = 1'b0;
    logic [ADDR_W-1:0] r_addr = '0;
    int                r_beat = 0;

    // previous-sample copies for the stability monitor
    bit                p_rst = 1'b1;
    bit                p_awv = 1'b0, p_awhs = 1'b0;
    bit                p_wv = 1'b0, p_whs = 1'b0, p_wlast = 1'b0;
    bit                p_arv = 1'b0, p_arhs = 1'b0;
    logic [ADDR_W-1:0] p_awaddr = '0, p_araddr = '0;
    logic [127:0]      p_wdata = '0;

    // Handshakes are sampled at the falling edge (values are what the DUT
    // sees at the next rising edge) and applied just after that rising edge.
    always begin
        bit                s_rst, s_aw, s_w, s_wlast, s_b, s_ar, s_r;
        logic [ADDR_W-1:0] s_awaddr, s_araddr, a;
        logic [127:0]      s_wdata;
        @(negedge clk);
        s_rst    = !aresetn;
        s_aw     = awvalid && awready;
        s_awaddr = awaddr;
        s_w      = wvalid && wready;
        s_wdata  = wdata;
        s_wlast  = wlast;
        s_b      = bvalid && bready;
        s_ar     = arvalid && arready;
        s_araddr = araddr;
        s_r      = rvalid && rready;

        if (!p_rst) begin
            if (p_awv && !p_awhs && (!awvalid || awaddr !== p_awaddr)) stab_viol++;
            if (p_wv && !p_whs && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)) stab_viol++;
            if (p_arv && !p_arhs && (!arvalid || araddr !== p_araddr)) stab_viol++;
        end
        p_rst = s_rst;
        p_awv = awvalid; p_awhs = s_aw; p_awaddr = awaddr;
        p_wv = wvalid; p_whs = s_w; p_wdata = wdata; p_wlast = wlast;
        p_arv = arvalid; p_arhs = s_ar; p_araddr = araddr;

        @(posedge clk);
        #1;
        if (s_rst) begin
            bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            w_beat = 0; b_pend = 1'b0; r_active = 1'b0; r_beat = 0;
        end else begin
            if (s_aw) begin
                if (aw_count < 16) aw_log[aw_count] = s_awaddr;
                aw_count++;
                cur_aw = s_awaddr;
                w_beat = 0;
            end
            if (s_w) begin
                mem[(cur_aw >> 4) + ADDR_W'(w_beat) & 63] = s_wdata;
                if (s_wlast != (w_beat == BL - 1)) wlast_viol++;
                if (cur_aw == ADDR_W'('h40) && w_beat == 0) cap_b1 = s_wdata;
                w_beat++;
                w_total++;
                if (w_beat == BL) begin
                    b_pend = 1'b1;
                    w_beat = 0;
                end
            end
            if (s_b) bvalid = 1'b0;
            if (b_pend && !bvalid) begin
                bvalid = 1'b1;
                bresp  = (aw_count - 1 == slverr_burst) ? 2'b10 : 2'b00;
                b_pend = 1'b0;
            end
            if (s_ar) begin
                r_active = 1'b1;
                r_addr   = s_araddr;
                r_beat   = 0;
                ar_count++;
            end
            if (s_r) begin
                r_beat++;
                r_total++;
                rvalid = 1'b0;
                rlast  = 1'b0;
                if (r_beat == BL) r_active = 1'b0;
            end
            if (r_active && !rvalid && !(rgap_mode && $urandom_range(0, 1) == 1)) begin
                a      = r_addr + ADDR_W'(16 * r_beat);
                rdata  = mem[a[9:4]];
                if (a == corrupt_addr) rdata[0] = ~rdata[0];
                rresp  = (a == rerr_addr) ? 2'b10 : 2'b00;
                rlast  = (r_beat == BL - 1);
                rvalid = 1'b1;
            end
        end
        awready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic clear_stats();
        aw_count   = 0;
        ar_count   = 0;
        w_total    = 0;
        r_total    = 0;
        wlast_viol = 0;
        stab_viol  = 0;
        cap_b1     = '0;
    endtask

    task automatic pulse_start(input logic [31:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 6000; i++) begin
            if (done) break;
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(negedge clk);

        // reset state
        check_eq("rst_busy",    busy, 0);
        check_eq("rst_done",    done, 0);
        check_eq("rst_pass",    pass, 0);
        check_eq("rst_err",     err_count, 0);
        check_eq("rst_first",   first_err_addr, 0);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid",  wvalid, 0);
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_awaddr",  awaddr, 0);
        check_eq("rst_wdata",   wdata, 0);
        aresetn    = 1'b1;
        calib_done = 1'b1;

        // clean pass, seed 0
        clear_stats();
        pulse_start(32'h0);
        wait_done();
        check_eq("clean_done", done, 1);
        check_eq("clean_pass", pass, 1);
        check_eq("clean_err",  err_count, 0);
        check_eq("clean_awcnt", aw_count, NB);
        for (int i = 0; i < NB; i++)
            check_eq($sformatf("clean_awaddr%0d", i), aw_log[i], 128'(i * 64));
        check_eq("clean_wbeats", w_total, NB * BL);
        check_eq("clean_rbeats", r_total, NB * BL);
        check_eq("clean_b1_wdata", cap_b1, 128'h00000043_00000042_00000041_00000040);
        check_eq("clean_wlast", wlast_viol, 0);

        // corrupted read beat at 0x050
        corrupt_addr = ADDR_W'('h50);
        clear_stats();
        pulse_start(32'h0);
        wait_done();
        corrupt_addr = none_addr;
        check_eq("inj_done",  done, 1);
        check_eq("inj_err",   err_count, 1);
        check_eq("inj_first", first_err_addr, 'h50);
        check_eq("inj_pass",  pass, 0);

        // backpressure with a nonzero seed
        bp_mode   = 1'b1;
        rgap_mode = 1'b1;
        clear_stats();
        pulse_start(32'hDEADBEEF);
        wait_done();
        bp_mode   = 1'b0;
        rgap_mode = 1'b0;
        check_eq("bp_done",   done, 1);
        check_eq("bp_pass",   pass, 1);
        check_eq("bp_err",    err_count, 0);
        check_eq("bp_stable", stab_viol, 0);
        check_eq("bp_wlast",  wlast_viol, 0);
        check_eq("bp_wbeats", w_total, NB * BL);
        check_eq("bp_rbeats", r_total, NB * BL);
        check_eq("bp_b1_wdata", cap_b1, 128'hDEADBEAC_DEADBEAD_DEADBEAE_DEADBEAF);

        // start gating
        calib_done = 1'b0;
        clear_stats();
        pulse_start(32'h0);
        repeat (20) @(negedge clk);
        check_eq("gate_nocal_busy",  busy, 0);
        check_eq("gate_nocal_awcnt", aw_count, 0);
        calib_done = 1'b1;
        pulse_start(32'h0);
        repeat (3) @(negedge clk);
        check_eq("gate_busy", busy, 1);
        pulse_start(32'h12345678);
        wait_done();
        check_eq("gate_awcnt", aw_count, NB);
        check_eq("gate_arcnt", ar_count, NB);
        check_eq("gate_pass",  pass, 1);

        // response errors: SLVERR on write burst 2 and read beat 0x150
        slverr_burst = 2;
        rerr_addr    = ADDR_W'('h150);
        clear_stats();
        pulse_start(32'h0);
        wait_done();
        slverr_burst = -1;
        rerr_addr    = none_addr;
        check_eq("resp_err",   err_count, 2);
        check_eq("resp_first", first_err_addr, 'h80);
        check_eq("resp_pass",  pass, 0);

        // reset in the middle of write data
        clear_stats();
        pulse_start(32'h0);
        for (int i = 0; i < 200 && w_total < 2; i++) @(negedge clk);
        check_eq("mid_reach_beat1", (w_total >= 2), 1);
        aresetn = 1'b0;
        @(negedge clk);
        check_eq("mid_awvalid", awvalid, 0);
        check_eq("mid_wvalid",  wvalid, 0);
        check_eq("mid_wlast",   wlast, 0);
        check_eq("mid_busy",    busy, 0);
        check_eq("mid_done",    done, 0);
        check_eq("mid_wdata",   wdata, 0);
        check_eq("mid_awaddr",  awaddr, 0);
        aresetn = 1'b1;
        @(negedge clk);
        clear_stats();
        pulse_start(32'h0);
        wait_done();
        check_eq("mid_restart_done", done, 1);
        check_eq("mid_restart_pass", pass, 1);
        check_eq("mid_restart_awcnt", aw_count, NB);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
